// File: rtl/uart_frame_tx_pkg.sv
// uart_frame_tx_pkg: shared FSM state type and width helpers for the tagged-frame UART sender.
package uart_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HDR  = 3'd2,
        DATA = 3'd3,
        TRL  = 3'd4,
        GAP  = 3'd5
    } state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // counter/index width, never below one bit
    function automatic int width_of(input int v);
        return clog2(v) < 1 ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serializer, LSB first; a start on the done cycle chains the next byte with no idle.
module uart_byte_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int CLK_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = width_of(CLK_DIV);

    logic [CW-1:0] cnt;
    logic [3:0]    bitn;
    logic [7:0]    sh;
    logic          act;
    logic          last;

    assign last = cnt == CW'(CLK_DIV - 1);
    assign done = act && last && bitn == 4'd9;
    assign busy = act;

    // ones shift in behind the data so the stop bit falls out of sh[0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act  <= 1'b0;
            cnt  <= '0;
            bitn <= '0;
            sh   <= '0;
            tx   <= 1'b1;
        end else if (start && (!act || done)) begin
            act  <= 1'b1;
            cnt  <= '0;
            bitn <= '0;
            sh   <= byte_in;
            tx   <= 1'b0;
        end else if (act) begin
            if (!last) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt  <= '0;
                bitn <= bitn + 1'b1;
                sh   <= {1'b1, sh[7:1]};
                tx   <= sh[0];
                act  <= bitn != 4'd9;
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: multi-channel tagged-frame UART sender (header, MSB-first data bytes, trailer)
// with round-robin channel selection, auto/gap or single-shot operation.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int                     CLK_DIV      = 5208,
    parameter int                     NUM_CH       = 2,
    parameter int                     BYTES_PER_CH = 4,
    parameter int                     GAP_CYCLES   = 2_400_000,
    parameter logic [NUM_CH*8-1:0]    HDR_TAGS     = {8'h63, 8'h74},
    parameter logic [NUM_CH*8-1:0]    TRL_TAGS     = {8'h79, 8'h78}
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CH*BYTES_PER_CH*8-1:0]    ch_data,
    input  logic [NUM_CH-1:0]                   ch_en,
    input  logic                                auto_mode,
    input  logic                                trigger,
    output logic                                uart_tx,
    output logic                                busy,
    output logic                                frame_done,
    output logic [width_of(NUM_CH)-1:0]         cur_ch
);

    localparam int DW = BYTES_PER_CH * 8;
    localparam int CW = width_of(NUM_CH);
    localparam int BW = width_of(BYTES_PER_CH);
    localparam int GW = width_of(GAP_CYCLES + 1);

    state_t        state;
    logic [CW-1:0] rr, pick;
    logic [DW-1:0] snap, pick_data;
    logic [BW-1:0] bcnt;
    logic [GW-1:0] gcnt;
    logic          kick;
    logic [7:0]    hdr, trl, byte_in;
    logic          b_start, b_done, b_busy;
    logic          last_byte;

    // first enabled channel at or after rr, wrapping
    always_comb begin
        pick = rr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_en[CW'((int'(rr) + k) % NUM_CH)]) pick = CW'((int'(rr) + k) % NUM_CH);
        end
    end

    always_comb begin
        pick_data = '0;
        hdr = '0;
        trl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick == CW'(i)) pick_data = ch_data[i*DW +: DW];
            if (cur_ch == CW'(i)) begin
                hdr = HDR_TAGS[8*i +: 8];
                trl = TRL_TAGS[8*i +: 8];
            end
        end
    end

    // the snapshot shifts left per data byte, so its top byte is always the next to send
    assign last_byte  = bcnt == BW'(BYTES_PER_CH - 1);
    assign b_start    = kick | (b_done & (state == HDR | state == DATA));
    assign byte_in    = kick ? hdr : (state == DATA && last_byte) ? trl : snap[DW-1 -: 8];
    assign frame_done = b_done & (state == TRL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr     <= '0;
            cur_ch <= '0;
            snap   <= '0;
            bcnt   <= '0;
            gcnt   <= '0;
            kick   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            kick <= 1'b0;
            case (state)
                IDLE: if ((auto_mode | trigger) && |ch_en && !b_busy) begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
                LOAD: if (|ch_en) begin
                    cur_ch <= pick;
                    rr     <= pick == CW'(NUM_CH - 1) ? '0 : pick + 1'b1;
                    snap   <= pick_data;
                    kick   <= 1'b1;
                    state  <= HDR;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                HDR: if (b_done) begin
                    state <= DATA;
                    bcnt  <= '0;
                    snap  <= snap << 8;
                end
                DATA: if (b_done) begin
                    if (last_byte) begin
                        state <= TRL;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                        snap <= snap << 8;
                    end
                end
                TRL: if (b_done) begin
                    state <= auto_mode ? GAP : IDLE;
                    busy  <= auto_mode;
                    gcnt  <= '0;
                end
                GAP: if (gcnt == GW'(GAP_CYCLES - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (b_start),
        .byte_in (byte_in),
        .tx      (uart_tx),
        .busy    (b_busy),
        .done    (b_done)
    );

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed bench with a serial line decoder; CLK_DIV=10, GAP_CYCLES=50.
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] ch_data;
    logic [1:0]  ch_en;
    logic        auto_mode = 1'b0;
    logic        trigger = 1'b0;
    logic        uart_tx, busy, frame_done;
    logic [0:0]  cur_ch;

    int n_chk = 0;
    int n_pass = 0;

    logic [8:0] rxq[$];
    logic [7:0] expq[$];
    int         chq[$];
    int         gapq[$];
    int         fd_cnt = 0;

    logic       rx_act = 1'b0;
    int         rx_cnt, rx_b;
    logic [7:0] rx_byte;
    logic       gap_on = 1'b0;
    int         gap_hi;

    uart_frame_tx #(
        .CLK_DIV      (10),
        .NUM_CH       (2),
        .BYTES_PER_CH (4),
        .GAP_CYCLES   (50),
        .HDR_TAGS     ({8'h63, 8'h74}),
        .TRL_TAGS     ({8'h79, 8'h78})
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_data    (ch_data),
        .ch_en      (ch_en),
        .auto_mode  (auto_mode),
        .trigger    (trigger),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done),
        .cur_ch     (cur_ch)
    );

    always #5 clk = ~clk;

    // line decoder sampling mid-bit on falling edges, plus frame_done / gap monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act = 1'b0;
            gap_on = 1'b0;
        end else begin
            if (!rx_act) begin
                if (uart_tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % 10 == 5) begin
                    rx_b = rx_cnt / 10;
                    if (rx_b >= 1 && rx_b <= 8) rx_byte[rx_b-1] = uart_tx;
                    else if (rx_b == 9) begin
                        rxq.push_back({uart_tx !== 1'b1, rx_byte});
                        rx_act = 1'b0;
                    end
                end
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                chq.push_back(int'(cur_ch));
                gap_on = 1'b1;
                gap_hi = 0;
            end else if (gap_on) begin
                if (uart_tx === 1'b1) gap_hi++;
                else begin
                    gapq.push_back(gap_hi);
                    gap_on = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_frame(input logic [7:0] h, input logic [31:0] d, input logic [7:0] t);
        expq.push_back(h);
        for (int i = 3; i >= 0; i--) expq.push_back(d[8*i +: 8]);
        expq.push_back(t);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_len"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            check($sformatf("%s_b%0d", tag, i), rxq[i], {1'b0, expq[i]});
        rxq.delete();
        expq.delete();
    endtask

    task automatic wait_bytes(input int n, input int budget);
        for (int i = 0; i < budget && rxq.size() < n; i++) @(posedge clk);
        #1;
    endtask

    // trigger is sampled on the second edge; returns 1ns after it
    task automatic pulse_trigger();
        @(posedge clk);
        #1 trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ch_data = {32'hDEADBEEF, 32'h12345678};
        ch_en   = 2'b01;
        tick(3);
        check("rst_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_ch", cur_ch, 0);
        rst_n = 1'b1;
        tick(5);
        check("idle_tx", uart_tx, 1);

        // single-shot frame and start latency
        fd_cnt = 0;
        pulse_trigger();
        check("t2_load_tx", uart_tx, 1);
        check("t2_load_busy", busy, 1);
        tick(1);
        check("t2_k1_tx", uart_tx, 1);
        tick(1);
        check("t2_start_bit", uart_tx, 0);
        tick(599);
        check("t2_done_pulse", frame_done, 1);
        check("t2_busy_last", busy, 1);
        tick(1);
        check("t2_done_off", frame_done, 0);
        check("t2_busy_off", busy, 0);
        tick(100);
        exp_frame(8'h74, 32'h12345678, 8'h78);
        check_rx("t2");
        check("t2_fd_cnt", fd_cnt, 1);
        check("t2_line_high", uart_tx, 1);

        // triggers while busy are ignored
        fd_cnt = 0;
        pulse_trigger();
        for (int i = 0; i < 29; i++) begin
            tick(19);
            trigger = 1'b1;
            tick(1);
            trigger = 1'b0;
        end
        tick(200);
        exp_frame(8'h74, 32'h12345678, 8'h78);
        check_rx("t6");
        check("t6_fd_cnt", fd_cnt, 1);

        // data change mid-frame does not reach the frame in flight
        pulse_trigger();
        tick(230);
        ch_data[31:0] = 32'hAAAAAAAA;
        tick(500);
        exp_frame(8'h74, 32'h12345678, 8'h78);
        check_rx("t5a");
        pulse_trigger();
        tick(700);
        exp_frame(8'h74, 32'hAAAAAAAA, 8'h78);
        check_rx("t5b");
        ch_data[31:0] = 32'h12345678;

        // async reset in the middle of a data byte
        auto_mode = 1'b1;
        for (int i = 0; i < 100 && uart_tx; i++) tick(1);
        tick(105);
        check("t1_pre_low", uart_tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_tx", uart_tx, 1);
        check("t1_rst_busy", busy, 0);
        tick(3);
        rxq.delete();
        rst_n = 1'b1;
        wait_bytes(6, 800);
        auto_mode = 1'b0;
        exp_frame(8'h74, 32'h12345678, 8'h78);
        check_rx("t1");
        for (int i = 0; i < 1000 && busy; i++) tick(1);
        check("t1_stop_busy", busy, 0);
        tick(100);
        check("t1_no_more", rxq.size(), 0);

        // auto round-robin over both channels with gap
        rst_n = 1'b0;
        tick(2);
        ch_en = 2'b11;
        auto_mode = 1'b1;
        rxq.delete();
        chq.delete();
        gapq.delete();
        rst_n = 1'b1;
        wait_bytes(18, 3000);
        exp_frame(8'h74, 32'h12345678, 8'h78);
        exp_frame(8'h63, 32'hDEADBEEF, 8'h79);
        exp_frame(8'h74, 32'h12345678, 8'h78);
        check_rx("t3");
        check("t3_nfd", chq.size() >= 2, 1);
        if (chq.size() >= 2) begin
            check("t3_ch0", chq[0], 0);
            check("t3_ch1", chq[1], 1);
        end
        check("t3_ngap", gapq.size() >= 1, 1);
        if (gapq.size() >= 1) check("t3_gap_len", gapq[0], 53);

        // only channel 1, then all channels off
        rst_n = 1'b0;
        tick(2);
        ch_en = 2'b10;
        rxq.delete();
        chq.delete();
        rst_n = 1'b1;
        wait_bytes(12, 2000);
        ch_en = 2'b00;
        exp_frame(8'h63, 32'hDEADBEEF, 8'h79);
        exp_frame(8'h63, 32'hDEADBEEF, 8'h79);
        check_rx("t4");
        tick(800);
        check("t4_quiet", rxq.size(), 0);
        check("t4_tx", uart_tx, 1);
        check("t4_busy", busy, 0);
        check("t4_nfd", chq.size(), 2);
        if (chq.size() == 2) check("t4_ch", chq[1], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
